// File: rtl/missile_launch_controller.sv
// Missile launch controller: picks a free slot round-robin on each fire-key edge,
// then holds off further launches for one frame plus a frame-counted cooldown.
module missile_launch_controller #(
    parameter int unsigned NUM_MISSILES    = 4,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned COUNT_WIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    fire_req,
    input  logic [NUM_MISSILES-1:0] missile_active,
    output logic [NUM_MISSILES-1:0] fire_pulse,
    output logic                    busy,
    output logic                    shot_blocked,
    output logic [3:0]              free_count,
    output logic [COUNT_WIDTH-1:0]  launch_count
);

    localparam int unsigned IDX_W = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1;
    localparam int unsigned CD_W  = 8;

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        pend_idx_q, pend_idx_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [CD_W-1:0]         cd_q, cd_d;
    logic [COUNT_WIDTH-1:0]  launch_cnt_q, launch_cnt_d;
    logic                    fire_q;
    logic                    hold_q, hold_d;

    logic [NUM_MISSILES-1:0] free_c;
    logic [IDX_W-1:0]        sel_c;
    logic [IDX_W-1:0]        idx_c;
    logic                    any_free_c;
    logic                    fire_edge_c;
    logic                    launch_c;

    // A slot is free when it is idle and not the one we just launched into.
    always_comb begin
        free_c = '0;
        for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
            free_c[i] = ~missile_active[i] & ~(pend_vld_q && (pend_idx_q == IDX_W'(i)));
        end
    end

    always_comb begin
        free_count = '0;
        for (int unsigned i = 0; i < NUM_MISSILES; i++) begin
            free_count = free_count + 4'(free_c[i]);
        end
    end

    // First free slot at or above rr_ptr, wrapping around.
    always_comb begin
        sel_c      = '0;
        idx_c      = '0;
        any_free_c = 1'b0;
        for (int unsigned k = 0; k < NUM_MISSILES; k++) begin
            idx_c = IDX_W'((32'(rr_ptr_q) + k) % NUM_MISSILES);
            if (!any_free_c && free_c[idx_c]) begin
                sel_c      = idx_c;
                any_free_c = 1'b1;
            end
        end
    end

    // hold_q masks a key still held from before reset until it is released.
    assign fire_edge_c = fire_req & ~fire_q & ~hold_q;
    assign launch_c    = fire_edge_c && (state_q == ST_READY) && any_free_c;
    assign hold_d      = hold_q & fire_req;

    always_comb begin
        fire_pulse = '0;
        if (launch_c) begin
            fire_pulse[sel_c] = 1'b1;
        end
    end

    assign shot_blocked = fire_edge_c & ~launch_c;
    assign busy         = (state_q != ST_READY);
    assign launch_count = launch_cnt_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        pend_idx_d   = pend_idx_q;
        pend_vld_d   = pend_vld_q;
        cd_d         = cd_q;
        launch_cnt_d = launch_cnt_q;
        case (state_q)
            ST_READY: begin
                if (launch_c) begin
                    pend_idx_d   = sel_c;
                    pend_vld_d   = 1'b1;
                    rr_ptr_d     = IDX_W'((32'(sel_c) + 32'd1) % NUM_MISSILES);
                    launch_cnt_d = launch_cnt_q + COUNT_WIDTH'(1);
                    state_d      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (startOfFrame) begin
                    pend_vld_d = 1'b0;
                    if (COOLDOWN_FRAMES == 0) begin
                        state_d = ST_READY;
                    end else begin
                        cd_d    = CD_W'(COOLDOWN_FRAMES);
                        state_d = ST_COOLDOWN;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (startOfFrame) begin
                    cd_d = cd_q - CD_W'(1);
                    if (cd_q <= CD_W'(1)) begin
                        cd_d    = '0;
                        state_d = ST_READY;
                    end
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_READY;
            rr_ptr_q     <= '0;
            pend_idx_q   <= '0;
            pend_vld_q   <= 1'b0;
            cd_q         <= '0;
            launch_cnt_q <= '0;
            fire_q       <= 1'b0;
            hold_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            pend_idx_q   <= pend_idx_d;
            pend_vld_q   <= pend_vld_d;
            cd_q         <= cd_d;
            launch_cnt_q <= launch_cnt_d;
            fire_q       <= fire_req;
            hold_q       <= hold_d;
        end
    end

endmodule

// File: tb/tb_missile_launch_controller.sv
// Directed-vector bench for missile_launch_controller with default parameters.
module tb_missile_launch_controller;

    localparam int NM       = 4;
    localparam int COOLDOWN = 8;

    logic          clk = 1'b0;
    logic          resetN;
    logic          startOfFrame;
    logic          fire_req;
    logic [NM-1:0] missile_active;
    logic [NM-1:0] fire_pulse;
    logic          busy;
    logic          shot_blocked;
    logic [3:0]    free_count;
    logic [7:0]    launch_count;

    int n_vec = 0;
    int n_err = 0;

    missile_launch_controller #(
        .NUM_MISSILES    (NM),
        .COOLDOWN_FRAMES (COOLDOWN),
        .COUNT_WIDTH     (8)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .fire_req       (fire_req),
        .missile_active (missile_active),
        .fire_pulse     (fire_pulse),
        .busy           (busy),
        .shot_blocked   (shot_blocked),
        .free_count     (free_count),
        .launch_count   (launch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN   = 1'b0;
        fire_req = 1'b0;
        startOfFrame = 1'b0;
        missile_active = '0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
        tick();
    endtask

    // Single fire-key press from READY/idle; checks the same-cycle outputs.
    task automatic fire_and_check(input string tag, input logic [NM-1:0] exp_fp, input logic exp_sb);
        fire_req = 1'b1;
        #1;
        check({tag, "_fp"}, 32'(fire_pulse), 32'(exp_fp));
        check({tag, "_sb"}, 32'(shot_blocked), 32'(exp_sb));
        tick();
        fire_req = 1'b0;
        tick();
    endtask

    task automatic run_out();
        repeat (COOLDOWN + 1) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    int n_fp;
    int n_sb;

    initial begin
        // Reset with the fire key already held.
        resetN = 1'b0;
        startOfFrame = 1'b0;
        missile_active = '0;
        fire_req = 1'b1;
        tick();
        #1;
        check("rst_fp",    32'(fire_pulse),   32'h0);
        check("rst_sb",    32'(shot_blocked), 32'h0);
        check("rst_busy",  32'(busy),         32'h0);
        check("rst_count", 32'(launch_count), 32'h0);
        check("rst_free",  32'(free_count),   32'd4);
        tick();
        resetN = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("held_fp", 32'(fire_pulse), 32'h0);
            tick();
        end
        fire_req = 1'b0;
        tick();
        tick();

        // First launch, then cooldown with a dropped shot after the 5th frame.
        fire_req = 1'b1;
        #1;
        check("l1_fp",   32'(fire_pulse), 32'h1);
        check("l1_busy", 32'(busy),       32'h0);
        tick();
        check("l1_fp_off", 32'(fire_pulse),   32'h0);
        check("l1_busy1",  32'(busy),         32'h1);
        check("l1_count",  32'(launch_count), 32'd1);
        check("l1_free",   32'(free_count),   32'd3);
        fire_req = 1'b0;
        tick();
        for (int p = 1; p <= COOLDOWN + 1; p++) begin
            startOfFrame = 1'b1;
            #1;
            check("cd_busy_pre", 32'(busy), 32'h1);
            tick();
            startOfFrame = 1'b0;
            check("cd_busy", 32'(busy), (p <= COOLDOWN) ? 32'h1 : 32'h0);
            tick();
            if (p == 5) begin
                fire_req = 1'b1;
                #1;
                check("cd_sb",    32'(shot_blocked), 32'h1);
                check("cd_fp",    32'(fire_pulse),   32'h0);
                tick();
                fire_req = 1'b0;
                check("cd_sb_off", 32'(shot_blocked), 32'h0);
                tick();
            end
        end
        check("cd_free", 32'(free_count), 32'd4);

        // Round-robin advance, then reset during cooldown with counter at 5.
        fire_and_check("l2", 4'b0010, 1'b0);
        repeat (4) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
        check("mid_busy", 32'(busy), 32'h1);
        resetN = 1'b0;
        #1;
        check("abort_busy",  32'(busy),         32'h0);
        check("abort_count", 32'(launch_count), 32'h0);
        check("abort_free",  32'(free_count),   32'd4);
        tick();
        resetN = 1'b1;
        tick();
        tick();
        fire_and_check("post_rst", 4'b0001, 1'b0);

        // Four launches filling every slot, then a blocked fifth.
        do_reset();
        for (int i = 0; i < NM; i++) begin
            logic [NM-1:0] exp_fp;
            exp_fp = NM'(1) << i;
            fire_and_check("fill", exp_fp, 1'b0);
            missile_active[i] = 1'b1;
            run_out();
        end
        fire_req = 1'b1;
        #1;
        check("full_sb",   32'(shot_blocked), 32'h1);
        check("full_fp",   32'(fire_pulse),   32'h0);
        check("full_free", 32'(free_count),   32'h0);
        tick();
        fire_req = 1'b0;
        tick();
        check("full_count", 32'(launch_count), 32'd4);
        check("full_busy",  32'(busy),         32'h0);

        // rr_ptr at 2 with slot 2 active, edge coincident with startOfFrame.
        missile_active = '0;
        fire_and_check("rr0", 4'b0001, 1'b0);
        run_out();
        fire_and_check("rr1", 4'b0010, 1'b0);
        run_out();
        missile_active = 4'b0100;
        fire_req = 1'b1;
        startOfFrame = 1'b1;
        #1;
        check("skip_free", 32'(free_count), 32'd3);
        check("skip_fp",   32'(fire_pulse), 32'h8);
        tick();
        startOfFrame = 1'b0;
        check("skip_busy",  32'(busy),         32'h1);
        check("skip_count", 32'(launch_count), 32'd7);
        fire_req = 1'b0;
        tick();
        run_out();

        // Fire key held for 100 cycles, cycling back to READY while held.
        missile_active = '0;
        fire_req = 1'b1;
        n_fp = 0;
        n_sb = 0;
        for (int c = 0; c < 100; c++) begin
            startOfFrame = ((c % 10) == 5);
            #1;
            if (|fire_pulse) n_fp++;
            if (shot_blocked) n_sb++;
            tick();
        end
        startOfFrame = 1'b0;
        check("hold_pulses",  32'(n_fp),         32'd1);
        check("hold_blocked", 32'(n_sb),         32'd0);
        check("hold_busy",    32'(busy),         32'h0);
        check("hold_count",   32'(launch_count), 32'd8);
        fire_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/missile_launch_controller.md
MISSILE_LAUNCH_CONTROLLER -- requirements
Module: missile_launch_controller

Interface
REQ-001 SHALL have parameter NUM_MISSILES, default 4, meaning number of missile slots controlled (range 1..8).
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 8, meaning frames between a launch completing and the next launch being accepted (range 0..255).
REQ-003 SHALL have parameter COUNT_WIDTH, default 8, meaning width of the launch counter.
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-005 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port startOfFrame  input  1  one-cycle pulse at the start of each frame.
REQ-007 SHALL have port fire_req  input  1  fire key level, active high.
REQ-008 SHALL have port missile_active  input  NUM_MISSILES  per-slot active flags returned by the missile slots.
REQ-009 SHALL have port fire_pulse  output  NUM_MISSILES  one-hot, one-cycle launch request to the selected slot.
REQ-010 SHALL have port busy  output  1  high whenever the state is not READY.
REQ-011 SHALL have port shot_blocked  output  1  one-cycle pulse when a fire edge is dropped.
REQ-012 SHALL have port free_count  output  4  number of slots that are neither active nor pending.
REQ-013 SHALL have port launch_count  output  COUNT_WIDTH  total launches issued since reset.

Function
REQ-014 SHALL detect a fire edge as fire_req high this cycle and registered fire_req low the previous cycle; holding fire_req SHALL NOT auto-repeat.
REQ-015 SHALL implement states READY, LAUNCH, COOLDOWN.
REQ-016 In READY with a fire edge and at least one free slot: SHALL select the first free slot searching upward from rr_ptr with wrap-around, assert fire_pulse[sel] in that same cycle (combinational from edge and state), record sel as pending, and enter LAUNCH on the next edge.
REQ-017 In READY with a fire edge and no free slot: SHALL assert shot_blocked for that cycle, issue no fire_pulse, and remain in READY.
REQ-018 On each launch, rr_ptr SHALL become (sel+1) mod NUM_MISSILES and launch_count SHALL increment by 1, wrapping from all-ones to 0.
REQ-019 In LAUNCH: on startOfFrame SHALL clear pending, load cooldown counter with COOLDOWN_FRAMES, and enter COOLDOWN; if COOLDOWN_FRAMES is 0, SHALL enter READY directly.
REQ-020 In COOLDOWN: on each startOfFrame the counter SHALL decrement by 1; the startOfFrame that takes it to 0 SHALL transition to READY.
REQ-021 Fire edges in LAUNCH or COOLDOWN SHALL be dropped with a shot_blocked pulse; no queuing.
REQ-022 A slot SHALL count as free only when missile_active[i] is 0 and i is not the pending slot.
REQ-023 free_count SHALL be a combinational population count of free slots.
REQ-024 A fire edge coincident with startOfFrame in READY SHALL launch normally; the slot latches it for the following frame.
REQ-025 Changes of missile_active (e.g. collision clears) SHALL take effect on free-slot selection in the same cycle.
REQ-026 fire_pulse SHALL never have more than one bit set and SHALL be all-zero outside READY.

Reset
REQ-027 While resetN is low: state READY, rr_ptr 0, pending cleared, cooldown counter 0, launch_count 0, registered fire_req 0; fire_pulse 0 and shot_blocked 0.
REQ-028 Reset asserted mid-LAUNCH or mid-COOLDOWN SHALL abort immediately; fire_req held high across reset release SHALL NOT produce a launch until released and re-pressed.

Verification
REQ-029 Reset, all slots inactive, fire_req 0->1 -> fire_pulse=4'b0001 for exactly one cycle, busy=1 next cycle, launch_count=1.
REQ-030 COOLDOWN_FRAMES=8, launch then 9 startOfFrame pulses -> busy drops on the 9th pulse (1 for LAUNCH exit + 8 cooldown); fire edge after 5th pulse -> shot_blocked pulse, no fire_pulse.
REQ-031 Four launches with missile_active tracking each -> fire_pulse sequence 0001,0010,0100,1000; fifth edge with all active -> shot_blocked=1, free_count=0.
REQ-032 rr_ptr=2, missile_active=4'b0100 -> fire edge selects slot 3 (fire_pulse=4'b1000).
REQ-033 fire_req held high 100 cycles through READY -> exactly one fire_pulse.
REQ-034 resetN low during COOLDOWN with counter 5 -> busy=0 immediately; fire edge after release -> launch to slot 0.
